// File: rtl/nv_fpga_unit_checkbox_mem_dut_axi_req_seq_256.sv
// AXI request sequencer for the checkbox memory DUT: issues reg_pg_req_num AW/AR commands,
// streams write beats, throttles on outstanding bursts, and drains before signalling done.
module nv_fpga_unit_checkbox_mem_dut_axi_req_seq_256 #(
  parameter int MAX_OUTST = 8
) (
  input  logic        pg_clk,
  input  logic        pg_rst,
  input  logic        pg_start,
  input  logic        pg_abort,
  input  logic [15:0] reg_pg_req_num,
  input  logic        pg_cmd_rw,
  input  logic [7:0]  pg_cmd_len,
  input  logic        aw_ready,
  input  logic        ar_ready,
  input  logic        w_ready,
  input  logic        b_done,
  input  logic        r_done,
  output logic        aw_valid,
  output logic        ar_valid,
  output logic        w_valid,
  output logic        w_last,
  output logic        status_clear,
  output logic        axi_req_update,
  output logic        awcmd_info_update,
  output logic        arcmd_info_update,
  output logic [15:0] axi_req_wd_cnt,
  output logic [8:0]  axi_wdata_phase_cnt_reg,
  output logic        pg_busy,
  output logic        pg_done,
  output logic [15:0] pg_issued_cnt,
  output logic [7:0]  pg_outst_cnt
);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, WDATA, DRAIN, DONE} state_t;
  state_t state;

  logic       aw_hs, ar_hs, w_hs, last_hs, issue, run_end;
  logic [1:0] ret_sum;
  logic [7:0] outst_sum, outst_nxt;
  logic [8:0] phase_inc;

  assign aw_hs   = aw_valid & aw_ready;
  assign ar_hs   = ar_valid & ar_ready;
  assign w_hs    = w_valid & w_ready;
  assign last_hs = w_hs & w_last;
  assign issue   = aw_hs | ar_hs;
  assign run_end = (pg_issued_cnt == reg_pg_req_num) | pg_abort;

  // Write address handshake deliberately does not advance the generator: its fields feed wstrb.
  assign axi_req_update    = ar_hs | last_hs;
  assign awcmd_info_update = b_done & ~pg_rst;
  assign arcmd_info_update = r_done & ~pg_rst;

  // Outstanding never exceeds MAX_OUTST (<=255), so 8 bits hold the sum; retirements saturate at 0.
  assign ret_sum   = {1'b0, b_done} + {1'b0, r_done};
  assign outst_sum = pg_outst_cnt + {7'd0, issue};
  assign outst_nxt = ({6'd0, ret_sum} > outst_sum) ? 8'd0 : outst_sum - {6'd0, ret_sum};
  assign phase_inc = axi_wdata_phase_cnt_reg + 9'd1;

  always_ff @(posedge pg_clk or posedge pg_rst) begin
    if (pg_rst) begin
      state                   <= IDLE;
      aw_valid                <= 1'b0;
      ar_valid                <= 1'b0;
      w_valid                 <= 1'b0;
      w_last                  <= 1'b0;
      status_clear            <= 1'b0;
      pg_busy                 <= 1'b0;
      pg_done                 <= 1'b0;
      axi_req_wd_cnt          <= '0;
      axi_wdata_phase_cnt_reg <= '0;
      pg_issued_cnt           <= '0;
      pg_outst_cnt            <= '0;
    end else begin
      status_clear <= 1'b0;
      pg_done      <= 1'b0;
      if (state != IDLE && state != CLEAR) pg_outst_cnt <= outst_nxt;
      if (issue) pg_issued_cnt <= pg_issued_cnt + 16'd1;
      if (w_hs) axi_req_wd_cnt <= axi_req_wd_cnt + 16'd1;

      case (state)
        IDLE: begin
          if (pg_start) begin
            state        <= CLEAR;
            status_clear <= 1'b1;
            pg_busy      <= 1'b1;
          end
        end
        CLEAR: begin
          pg_issued_cnt           <= '0;
          axi_req_wd_cnt          <= '0;
          axi_wdata_phase_cnt_reg <= '0;
          pg_outst_cnt            <= '0;
          state                   <= ISSUE;
        end
        ISSUE: begin
          // An asserted valid is held until accepted, abort or not.
          if (ar_valid) begin
            if (ar_ready) ar_valid <= 1'b0;
          end else if (aw_valid) begin
            if (aw_ready) begin
              aw_valid                <= 1'b0;
              w_valid                 <= 1'b1;
              w_last                  <= (pg_cmd_len == 8'd0);
              axi_wdata_phase_cnt_reg <= '0;
              state                   <= WDATA;
            end
          end else if (run_end) begin
            state <= DRAIN;
          end else if (pg_outst_cnt < 8'(MAX_OUTST)) begin
            if (pg_cmd_rw) ar_valid <= 1'b1;
            else           aw_valid <= 1'b1;
          end
        end
        WDATA: begin
          if (w_hs) begin
            if (w_last) begin
              w_valid                 <= 1'b0;
              w_last                  <= 1'b0;
              axi_wdata_phase_cnt_reg <= '0;
              state                   <= run_end ? DRAIN : ISSUE;
            end else begin
              axi_wdata_phase_cnt_reg <= phase_inc;
              w_last                  <= (phase_inc == {1'b0, pg_cmd_len});
            end
          end
        end
        DRAIN: begin
          if (pg_outst_cnt == 8'd0) begin
            state   <= DONE;
            pg_done <= 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          pg_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nv_fpga_unit_checkbox_mem_dut_axi_req_seq_256.md
NV_FPGA_UNIT_CHECKBOX_MEM_DUT_AXI_REQ_SEQ_256 -- requirements
Module: NV_FPGA_unit_checkbox_mem_dut_axi_req_seq_256

Interface
REQ-001 Parameter MAX_OUTST, default 8, maximum commands issued but not yet retired (range 1..255).
REQ-002 pg_clk  input  1  sole clock; all state on rising edge.
REQ-003 pg_rst  input  1  reset, asynchronous, active-high.
REQ-004 pg_start  input  1  one-cycle run request.
REQ-005 pg_abort  input  1  level; stop issuing new commands.
REQ-006 reg_pg_req_num  input  16  commands per run.
REQ-007 pg_cmd_rw  input  1  direction of current generator command (1=read).
REQ-008 pg_cmd_len  input  8  AXI len of current command (beats-1).
REQ-009 aw_ready / ar_ready / w_ready  input  1 each  AXI channel ready.
REQ-010 b_done / r_done  input  1 each  one-cycle pulse per retired write / read burst (B received / R last received).
REQ-011 aw_valid / ar_valid / w_valid / w_last  output  1 each  AXI channel controls.
REQ-012 status_clear  output  1  generator preset pulse.
REQ-013 axi_req_update  output  1  advance generator command.
REQ-014 awcmd_info_update / arcmd_info_update  output  1 each  advance generator expected-ID trackers.
REQ-015 axi_req_wd_cnt  output  16  write beats accepted since clear.
REQ-016 axi_wdata_phase_cnt_reg  output  9  beat index within current write burst.
REQ-017 pg_busy  output  1  run in progress; pg_done  output  1  one-cycle run completion.
REQ-018 pg_issued_cnt  output  16  commands issued; pg_outst_cnt  output  8  commands outstanding.

Function
REQ-019 FSM states: IDLE, CLEAR, ISSUE, WDATA, DRAIN, DONE; all outputs registered except the handshake-derived pulses of REQ-024/025.
REQ-020 IDLE: pg_start -> CLEAR; pg_start in any other state is ignored.
REQ-021 CLEAR: exactly one cycle, status_clear=1, counters (issued, wd_cnt, phase, outst) zeroed; next ISSUE.
REQ-022 ISSUE: if issued==reg_pg_req_num or pg_abort -> DRAIN; else if outst<MAX_OUTST assert aw_valid (pg_cmd_rw=0) or ar_valid (pg_cmd_rw=1); else wait with valids low.
REQ-023 Once asserted, aw_valid/ar_valid held with stable command until ready; pg_abort does not withdraw an asserted valid.
REQ-024 Read handshake (ar_valid&ar_ready): axi_req_update=1 same cycle, issued+1, outst+1, stay ISSUE (valid deasserts next cycle for at least one cycle).
REQ-025 Write handshake (aw_valid&aw_ready): issued+1, outst+1, phase=0, -> WDATA; axi_req_update is NOT asserted here so generator fields stay stable for wstrb.
REQ-026 WDATA: w_valid=1; w_last=1 when phase==pg_cmd_len; each w_valid&w_ready increments axi_req_wd_cnt (16-bit wrap) and phase.
REQ-027 Last-beat handshake: axi_req_update=1 same cycle, phase=0, -> ISSUE (or DRAIN if count reached / pg_abort); pg_abort never truncates a burst.
REQ-028 awcmd_info_update = b_done; arcmd_info_update = r_done; each retirement decrements outst in any non-IDLE state.
REQ-029 Simultaneous issue and retirement in one cycle: outst unchanged; retirement with outst==0 ignored (no underflow).
REQ-030 DRAIN: no new valids; outst==0 -> DONE.
REQ-031 DONE: pg_done=1 one cycle -> IDLE; counters hold values until next CLEAR.
REQ-032 reg_pg_req_num==0: CLEAR -> ISSUE -> DRAIN -> DONE with no AXI valid asserted.
REQ-033 pg_busy=1 in all states except IDLE.
REQ-034 reg_pg_req_num, pg_cmd_len sampled live; software keeps them stable during a run.

Reset
REQ-035 pg_rst asserted (any time, including mid-burst): state IDLE, all outputs and counters 0 immediately, no pg_done.
REQ-036 After pg_rst release, no activity until pg_start.

Verification
REQ-037 req_num=4, rw alternating (W,R,W,R), len=3, ready always 1, b_done/r_done 5 cycles after issue -> 8 write beats, wd_cnt=8, 4 axi_req_update pulses, pg_done once, issued=4.
REQ-038 MAX_OUTST=2, req_num=5 reads, r_done withheld -> ar_valid stops after 2 issues, outst=2; release one r_done -> exactly one more issue.
REQ-039 pg_abort asserted at write beat 2 of len=7 -> all 8 beats with w_last on 8th, no further aw_valid, pg_done after outst reaches 0.
REQ-040 req_num=0, pg_start -> status_clear pulse, pg_done 3 cycles later, no valids.
REQ-041 pg_rst pulsed during WDATA phase 4 -> w_valid, pg_busy, counters 0 at once; new pg_start runs cleanly.
REQ-042 w_ready toggling 1/0 each cycle, len=15 -> phase 0..15, w_last only on beat 15, axi_req_update only on that beat's handshake.
